// File: rtl/glitch_cmd_master.sv
// Host-side command initiator: serialises requests to the injector UART and checks its replies.
// Optional stray-byte counter enabled by GLITCH_CMD_MASTER_STRAY_CNT_EN.
module glitch_cmd_master #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [31:0] req_value,
   output logic        rsp_valid,
   output logic [31:0] rsp_data,
   output logic [1:0]  rsp_code,
   output logic        tx_start,
   output logic [7:0]  tx_data,
   input  logic        tx_busy,
   input  logic        rx_done,
   input  logic [7:0]  rx_data,
   output logic [15:0] stray_cnt
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [1:0] K_NONE = 2'd0, K_GET = 2'd1, K_PING = 2'd2, K_ARM = 2'd3;

   typedef enum logic [2:0] {IDLE, SEND, TX_ARM, TX_WAIT, RX_WAIT, RESP} state_t;

   state_t        state, state_n;
   logic          alive;
   logic [39:0]   sh;
   logic [2:0]    tx_left, rx_left;
   logic [1:0]    kind;
   logic [31:0]   acc, res_data, rsp_data_q;
   logic [1:0]    res_code, rsp_code_q;
   logic [TW-1:0] tcnt;
   logic          accept;

   logic [7:0] d_cmd;
   logic       d_val, d_ok;
   logic [2:0] d_rsp;
   logic [1:0] d_kind;

   always_comb begin
      d_cmd  = 8'h00;
      d_val  = 1'b0;
      d_rsp  = 3'd0;
      d_kind = K_NONE;
      d_ok   = 1'b1;
      case (req_op)
         4'd0:  begin d_cmd = 8'hA0; d_val = 1'b1; end
         4'd1:  begin d_cmd = 8'hA1; d_val = 1'b1; end
         4'd2:  begin d_cmd = 8'hA2; d_val = 1'b1; end
         4'd3:  begin d_cmd = 8'hB0; d_rsp = 3'd4; d_kind = K_GET; end
         4'd4:  begin d_cmd = 8'hB1; d_rsp = 3'd4; d_kind = K_GET; end
         4'd5:  begin d_cmd = 8'hB2; d_rsp = 3'd4; d_kind = K_GET; end
         4'd6:  begin d_cmd = 8'hC0; d_rsp = 3'd1; d_kind = K_PING; end
         4'd7:  d_cmd = 8'h01;
         4'd8:  d_cmd = 8'h02;
         4'd9:  begin d_cmd = 8'h03; d_rsp = 3'd1; d_kind = K_ARM; end
         4'd10: d_cmd = 8'h04;
         default: d_ok = 1'b0;
      endcase
   end

   // alive keeps req_ready low until the first edge after reset release
   assign req_ready = alive && (state == IDLE);
   assign accept    = req_valid && req_ready;
   assign rsp_valid = (state == RESP);
   assign rsp_data  = rsp_data_q;
   assign rsp_code  = rsp_code_q;

   always_comb begin
      state_n  = state;
      res_data = 32'h0;
      res_code = 2'd0;
      tx_start = 1'b0;
      tx_data  = 8'h00;
      case (state)
         IDLE: begin
            if (accept) begin
               if (d_ok) begin
                  state_n = SEND;
               end else begin
                  state_n  = RESP;
                  res_code = 2'd3;
               end
            end
         end
         SEND: begin
            tx_data = sh[39:32];
            if (!tx_busy) begin
               tx_start = 1'b1;
               state_n  = TX_ARM;
            end
         end
         TX_ARM: state_n = TX_WAIT;
         TX_WAIT: begin
            if (!tx_busy) begin
               if (tx_left != 3'd0)      state_n = SEND;
               else if (rx_left != 3'd0) state_n = RX_WAIT;
               else                      state_n = RESP;
            end
         end
         RX_WAIT: begin
            // a byte arriving on the expiry cycle wins over the timeout
            if (rx_done) begin
               if (rx_left == 3'd1) begin
                  state_n  = RESP;
                  res_data = {24'h0, rx_data};
                  case (kind)
                     K_GET:  res_data = {acc[23:0], rx_data};
                     K_PING: if (rx_data != 8'h42) res_code = 2'd2;
                     K_ARM: begin
                        if (rx_data[7:1] == 7'b1111000) res_data = {31'h0, rx_data[0]};
                        else                            res_code = 2'd2;
                     end
                     default: res_data = 32'h0;
                  endcase
               end
            end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
               state_n  = RESP;
               res_code = 2'd1;
            end
         end
         RESP: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         alive      <= 1'b0;
         sh         <= 40'h0;
         tx_left    <= 3'd0;
         rx_left    <= 3'd0;
         kind       <= K_NONE;
         acc        <= 32'h0;
         tcnt       <= '0;
         rsp_data_q <= 32'h0;
         rsp_code_q <= 2'd0;
      end else begin
         state <= state_n;
         alive <= 1'b1;
         if (accept) begin
            sh      <= {d_cmd, req_value};
            tx_left <= d_val ? 3'd5 : 3'd1;
            rx_left <= d_rsp;
            kind    <= d_kind;
            tcnt    <= '0;
         end
         if (tx_start) begin
            sh      <= {sh[31:0], 8'h00};
            tx_left <= tx_left - 3'd1;
         end
         if (state == RX_WAIT) begin
            if (rx_done) begin
               acc     <= {acc[23:0], rx_data};
               rx_left <= rx_left - 3'd1;
               tcnt    <= '0;
            end else begin
               tcnt <= tcnt + 1'b1;
            end
         end
         if (state_n == RESP) begin
            rsp_data_q <= res_data;
            rsp_code_q <= res_code;
         end
      end
   end

`ifdef GLITCH_CMD_MASTER_STRAY_CNT_EN
   logic [15:0] stray;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stray <= 16'h0;
      else if (rx_done && state != RX_WAIT && stray != 16'hFFFF)
         stray <= stray + 16'h1;
   end

   assign stray_cnt = stray;
`else
   assign stray_cnt = 16'h0;
`endif

endmodule

// File: doc/glitch_cmd_master.md
Name: glitch_cmd_master

Overview:
- Host-side initiator for the glitcher's byte-serial command protocol; sits between a local request interface (sequencer/sweep engine) and a UART TX/RX pair whose far end is the fault injector.
- Serialises each request into a command byte plus an optional 4-byte big-endian value.
- Collects and checks the injector's response bytes, enforces a response timeout, and returns one result per request.

Parameters:
- TIMEOUT_CYCLES, 1000000, consecutive cycles without a response byte before timeout error (>=2).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  1  request present
- req_ready  out  1  block idle, accepts request
- req_op  in  4  operation code (see Behaviour)
- req_value  in  32  value for SET ops
- rsp_valid  out  1  one-cycle result pulse
- rsp_data  out  32  returned value
- rsp_code  out  2  0 ok, 1 timeout, 2 bad response, 3 bad op
- tx_start  out  1  one-cycle pulse, send tx_data
- tx_data  out  8  byte to transmit
- tx_busy  in  1  transmitter busy
- rx_done  in  1  one-cycle pulse, rx_data valid
- rx_data  in  8  received byte
- stray_cnt  out  16  unexpected received bytes (optional feature)

Behaviour:
- Reset values: req_ready=0 while in reset and 1 from the first cycle after release; rsp_valid=0, rsp_data=0, rsp_code=0, tx_start=0, tx_data=0, stray_cnt=0. State is IDLE.
- Op map (op -> cmd byte, value bytes, response bytes):
  - 0 -> A0, 4, 0; 1 -> A1, 4, 0; 2 -> A2, 4, 0
  - 3 -> B0, 0, 4; 4 -> B1, 0, 4; 5 -> B2, 0, 4
  - 6 -> C0, 0, 1; 9 -> 03, 0, 1
  - 7 -> 01, 0, 0; 8 -> 02, 0, 0; 10 -> 04, 0, 0
  - 11..15 invalid
- req_ready=1 only in IDLE. A request is accepted on req_valid && req_ready. req_op and req_value are latched at acceptance.
- Invalid op: no bytes are sent. rsp_valid pulses the next cycle with rsp_code=3 and rsp_data=0.
- States: IDLE, SEND, TX_ARM, TX_WAIT, RX_WAIT, RESP.
- SEND:
  - When tx_busy=0, drive tx_data = current byte and pulse tx_start for one cycle, then go to TX_ARM.
  - Byte order: cmd byte, then value[31:24], [23:16], [15:8], [7:0].
- TX_ARM: exactly one cycle; tx_busy is ignored (transmitter raises busy the cycle after tx_start). Go to TX_WAIT.
- TX_WAIT: when tx_busy=0, go to SEND if bytes remain. Otherwise go to RX_WAIT if a response is expected, else to RESP with code 0 and data 0.
- RX_WAIT:
  - Each rx_done shifts rx_data into the accumulator, MSB first, and clears the timeout counter.
  - The counter increments every cycle without rx_done. Reaching TIMEOUT_CYCLES gives RESP with code 1 and data 0; partial bytes are discarded.
- Response checks:
  - GET: data = 4 assembled bytes, code 0.
  - PING: byte==42h gives code 0 and data 0x42; otherwise code 2 and data = {24'b0, byte}.
  - GET_ARM_STATE: byte[7:1]==7'b1111000 gives code 0 and data = {31'b0, byte[0]}; otherwise code 2 and data = {24'b0, byte}.
- RESP: rsp_valid=1 for one cycle with rsp_data/rsp_code; rsp_data/rsp_code hold until the next RESP. Return to IDLE; req_ready=1 the following cycle.
- Minimum request-to-rsp_valid latency for a no-response op with tx_busy never asserted: 4 cycles after acceptance.
- rx_done outside RX_WAIT (IDLE, SEND, TX_*, RESP): byte dropped, counted as stray.
- rx_done in the same cycle the timeout expires: the byte is taken and the timeout is cancelled.
- Reset mid-operation: immediate return to reset values; any partly sent frame is abandoned and no rsp_valid is issued.

Optional Feature:
- Macro GLITCH_CMD_MASTER_STRAY_CNT_EN.
- Defined: stray_cnt increments on every dropped rx_done byte and saturates at FFFFh; cleared only by reset.
- Undefined: stray_cnt is tied to 0 and no counter logic exists.

Test Plan:
- SET_WIDTH (op 1), value 0x00012345, tx_busy high 20 cycles per byte -> tx bytes A1,00,01,23,45 in order, one tx_start each, none while busy; rsp_valid with code 0.
- GET_OFFSET (op 3), responder returns 00,00,03,E8 spaced 50 cycles -> rsp_data=0x000003E8, code 0.
- PING with reply 42h -> code 0, data 0x42; PING with reply 41h -> code 2, data 0x41.
- GET_ARM_STATE, TIMEOUT_CYCLES=100, no reply -> rsp_valid exactly 100 cycles after RX_WAIT entry with code 1. Repeat with reply F1h -> data 1, code 0.
- op 12 -> no tx_start, rsp_valid next cycle with code 3. ARM (op 7) -> single byte 01h, code 0.
- With macro defined: 3 rx_done pulses while IDLE, then reset asserted mid-GET frame -> stray_cnt=3 before reset, 0 after; tx_start=0 and no rsp_valid after reset.
